// File: rtl/seg_byte_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : seg_byte_scroller
//  Description : Buffers a valid/ready byte stream in a small circular FIFO
//                and presents each byte on two hex-digit nibble outputs for a
//                programmable number of clock cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_byte_scroller #(
   parameter int DEPTH       = 8,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [3:0]               seg_data_1,
   output logic [3:0]               seg_data_2,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fill_level
);

   localparam int               C_AW        = $clog2(DEPTH);
   localparam logic [C_AW:0]    C_PTR_ONE   = (C_AW + 1)'(1);
   localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SHOW = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [C_AW:0]    r_wr_ptr;
   logic [C_AW:0]    r_rd_ptr;
   logic [7:0]       r_mem [DEPTH];
   logic [7:0]       r_disp;
   logic [CNT_W-1:0] r_cnt;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_cnt_last;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_full     = (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]) &&
                       (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]);
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_cnt_last = (r_cnt == C_HOLD_LAST);

   // No full-bypass: a full FIFO refuses input even when a pop is pending.
   assign in_ready   = !w_full && !clear;
   assign w_push     = in_valid && in_ready;

   assign seg_data_1 = r_disp[7:4];
   assign seg_data_2 = r_disp[3:0];
   assign busy       = (r_state == S_SHOW);
   assign fill_level = r_wr_ptr - r_rd_ptr;

   // State register; clear returns to IDLE ahead of any transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (clear) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and pop decision: load a new byte when idle or when the hold expires.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_state = S_SHOW;
            end
         end
         S_SHOW: begin
            if (w_cnt_last) begin
               if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_next_state = S_IDLE;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
      if (clear) begin
         w_pop = 1'b0;
      end
   end

   // FIFO storage write; contents need no reset because pointers gate reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[C_AW-1:0]] <= in_data;
      end
   end

   // Pointers, display register and hold counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_disp   <= 8'h00;
         r_cnt    <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_disp   <= 8'h00;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            r_disp   <= r_mem[r_rd_ptr[C_AW-1:0]];
            r_cnt    <= '0;
         end else if (r_state == S_SHOW) begin
            // Expiry with nothing queued drops to IDLE; the counter restarts.
            if (w_cnt_last) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + C_CNT_ONE;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_byte_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_byte_scroller
//  Description : Self-checking bench for seg_byte_scroller (DEPTH=4, HOLD=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_byte_scroller;

   localparam int DEPTH = 4;
   localparam int HOLD  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] seg_data_1;
   logic [3:0] seg_data_2;
   logic       busy;
   logic [2:0] fill_level;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: a byte queue, the byte on display, and its age.
   logic [7:0] m_q[$];
   logic [7:0] m_disp = 8'h00;
   bit         m_show = 1'b0;
   int         m_age  = 0;

   seg_byte_scroller #(
      .DEPTH      (DEPTH),
      .HOLD_CYCLES(HOLD),
      .CNT_W      (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .seg_data_1(seg_data_1),
      .seg_data_2(seg_data_2),
      .busy      (busy),
      .fill_level(fill_level)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic model_reset();
      m_q.delete();
      m_disp = 8'h00;
      m_show = 1'b0;
      m_age  = 0;
   endtask

   // One clock edge of the display rules, evaluated on pre-edge values.
   task automatic model_update();
      bit was_full;
      if (!rst_n) begin
         model_reset();
      end else if (clear) begin
         model_reset();
      end else begin
         was_full = (m_q.size() == DEPTH);
         if (!m_show) begin
            if (m_q.size() > 0) begin
               m_disp = m_q.pop_front();
               m_show = 1'b1;
               m_age  = 0;
            end
         end else if (m_age != HOLD - 1) begin
            m_age++;
         end else if (m_q.size() > 0) begin
            m_disp = m_q.pop_front();
            m_age  = 0;
         end else begin
            m_show = 1'b0;
         end
         if (in_valid && !was_full) m_q.push_back(in_data);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if ({seg_data_1, seg_data_2} !== 8'h00) begin n_fail++; $display("FAIL reset_seg: got %h expected 00", {seg_data_1, seg_data_2}); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      tick();
      // Queue two bytes behind one on display, then reset mid-hold.
      in_valid = 1'b1; in_data = 8'h11; tick();
      in_data = 8'h22; tick();
      in_data = 8'h33; tick();
      in_valid = 1'b0;
      n_cmp++; if (fill_level !== 3'd2) begin n_fail++; $display("FAIL midreset_pre_fill: got %0d expected 2", fill_level); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_busy: got %b expected 1", busy); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++; if ({seg_data_1, seg_data_2} !== 8'h00) begin n_fail++; $display("FAIL midreset_seg: got %h expected 00", {seg_data_1, seg_data_2}); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      n_cmp++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL midreset_fill: got %0d expected 0", fill_level); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_data = 8'hA5; tick();
      in_valid = 1'b0;
      n_cmp++; if (fill_level !== 3'd1) begin n_fail++; $display("FAIL single_fill: got %0d expected 1", fill_level); end
      n_cmp++; if ({seg_data_1, seg_data_2} !== 8'h00) begin n_fail++; $display("FAIL single_early: got %h expected 00", {seg_data_1, seg_data_2}); end
      for (int k = 1; k <= 7; k++) begin
         tick();
         n_cmp++; if (seg_data_1 !== 4'hA || seg_data_2 !== 4'h5) begin n_fail++; $display("FAIL single_seg[%0d]: got %h%h expected a5", k, seg_data_1, seg_data_2); end
         n_cmp++; if (busy !== (k <= HOLD)) begin n_fail++; $display("FAIL single_busy[%0d]: got %b expected %b", k, busy, (k <= HOLD)); end
      end
   endtask

   task automatic test_queue_order();
      logic [7:0] vals [3] = '{8'h12, 8'h34, 8'h56};
      logic [7:0] exp_b;
      in_valid = 1'b1; in_data = vals[0]; tick();
      for (int k = 1; k <= 14; k++) begin
         if (k <= 2) begin in_valid = 1'b1; in_data = vals[k]; end
         else in_valid = 1'b0;
         tick();
         exp_b = vals[(k <= 12) ? (k - 1) / HOLD : 2];
         n_cmp++; if ({seg_data_1, seg_data_2} !== exp_b) begin n_fail++; $display("FAIL queue_seg[%0d]: got %h expected %h", k, {seg_data_1, seg_data_2}, exp_b); end
         n_cmp++; if (busy !== (k <= 12)) begin n_fail++; $display("FAIL queue_busy[%0d]: got %b expected %b", k, busy, (k <= 12)); end
      end
   endtask

   task automatic test_full_wrap();
      int         nxt = 0;
      int         nseen = 0;
      logic [7:0] seen [16];
      logic [7:0] prev;
      bit         saw_full = 1'b0;
      prev = {seg_data_1, seg_data_2};
      for (int c = 0; c < 80; c++) begin
         in_valid = (nxt < 10);
         in_data  = 8'(nxt);
         #1;
         n_cmp++; if (in_ready !== (m_q.size() < DEPTH)) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected %b", c, in_ready, (m_q.size() < DEPTH)); end
         n_cmp++; if (fill_level !== 3'(m_q.size())) begin n_fail++; $display("FAIL wrap_fill[%0d]: got %0d expected %0d", c, fill_level, m_q.size()); end
         if (m_q.size() == DEPTH) saw_full = 1'b1;
         if (in_valid && m_q.size() < DEPTH) nxt++;
         tick();
         if ({seg_data_1, seg_data_2} != prev && nseen < 16) begin
            seen[nseen] = {seg_data_1, seg_data_2};
            nseen++;
         end
         prev = {seg_data_1, seg_data_2};
      end
      in_valid = 1'b0;
      n_cmp++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL wrap_reached_full: got %b expected 1", saw_full); end
      n_cmp++; if (nseen != 10) begin n_fail++; $display("FAIL wrap_count: got %0d expected 10", nseen); end
      for (int i = 0; i < 10 && i < nseen; i++) begin
         n_cmp++; if (seen[i] !== 8'(i)) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, seen[i], 8'(i)); end
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'h61 + 8'(i); tick();
      end
      in_valid = 1'b0;
      n_cmp++; if (fill_level !== 3'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL clear_pre: got fill %0d busy %b expected fill 3 busy 1", fill_level, busy); end
      clear = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b expected 0", in_ready); end
      tick();
      clear = 1'b0; in_valid = 1'b0;
      n_cmp++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL clear_fill: got %0d expected 0", fill_level); end
      for (int k = 0; k < 8; k++) begin
         n_cmp++; if ({seg_data_1, seg_data_2} !== 8'h00) begin n_fail++; $display("FAIL clear_seg[%0d]: got %h expected 00", k, {seg_data_1, seg_data_2}); end
         n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy[%0d]: got %b expected 0", k, busy); end
         tick();
      end
   endtask

   task automatic test_simul_push_pop();
      in_valid = 1'b1; in_data = 8'h71; tick();
      in_data = 8'h72; tick();
      in_data = 8'h73; tick();
      in_valid = 1'b0; tick(); tick();
      n_cmp++; if (fill_level !== 3'd2 || {seg_data_1, seg_data_2} !== 8'h71) begin n_fail++; $display("FAIL simul_pre: got fill %0d seg %h expected fill 2 seg 71", fill_level, {seg_data_1, seg_data_2}); end
      in_valid = 1'b1; in_data = 8'h74; tick();
      in_valid = 1'b0;
      n_cmp++; if (fill_level !== 3'd2) begin n_fail++; $display("FAIL simul_fill: got %0d expected 2", fill_level); end
      n_cmp++; if ({seg_data_1, seg_data_2} !== 8'h72) begin n_fail++; $display("FAIL simul_seg: got %h expected 72", {seg_data_1, seg_data_2}); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy: got %b expected 1", busy); end
      repeat (16) tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 8'($urandom);
         clear    = ($urandom_range(0, 60) == 0);
         #1;
         n_cmp++; if (in_ready !== (m_q.size() < DEPTH && !clear)) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, (m_q.size() < DEPTH && !clear)); end
         tick();
         n_cmp++; if ({seg_data_1, seg_data_2} !== m_disp) begin n_fail++; $display("FAIL rand_seg[%0d]: got %h expected %h", c, {seg_data_1, seg_data_2}, m_disp); end
         n_cmp++; if (busy !== m_show) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy, m_show); end
         n_cmp++; if (fill_level !== 3'(m_q.size())) begin n_fail++; $display("FAIL rand_fill[%0d]: got %0d expected %0d", c, fill_level, m_q.size()); end
      end
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_queue_order();
      test_full_wrap();
      test_clear();
      test_simul_push_pop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
